m68k_bus_master: RTL and testbench
==================================

Name: m68k_bus_master

Overview:
- Synchronous 68000-style bus initiator clocked from CLK8.
- Gives internal logic (DMA, blitter-style copy, self-test) a simple request/acknowledge port.
- Arbitrates for the ST bus (BR/BG/BGACK), runs one word or byte cycle with AS/UDS/LDS/RW, terminates on DTACK, BERR, VPA/E (6800 cycle) or timeout, then releases the bus.
- It is the initiator counterpart to the existing altram/SDRAM responder path.

Parameters:
- TIMEOUT_CYCLES, 64: CLK8 cycles in WAIT before a timeout abort.
- E_SYNC, 1: 1 enables VPA/E synchronous peripheral cycles; 0 treats VPA as a bus error.

Ports:
- CLK8  in  1  bus clock; all logic is on the posedge.
- RST  in  1  synchronous, active-low reset.
- REQ  in  1  request strobe, sampled in IDLE only.
- REQ_RW  in  1  1 = read, 0 = write.
- REQ_A  in  23  word address A[23:1].
- REQ_UDS  in  1  upper byte enable, active-low.
- REQ_LDS  in  1  lower byte enable, active-low.
- REQ_D  in  16  write data.
- ACK  out  1  one-cycle completion pulse.
- RSP_D  out  16  read data, valid with ACK.
- RSP_ERR  out  2  00 ok, 01 BERR, 10 timeout, 11 rejected (no strobe).
- BUSY  out  1  high from request accept until ACK.
- BR  out  1  bus request, active-low.
- BG  in  1  bus grant, active-low.
- BGACK  out  1  bus grant acknowledge, active-low.
- BUS_OE  out  1  enables drivers for A, AS, UDS, LDS, RW.
- A  out  23  bus address.
- AS  out  1  address strobe, active-low.
- UDS  out  1  upper data strobe, active-low.
- LDS  out  1  lower data strobe, active-low.
- RW  out  1  read/write.
- D_OUT  out  16  write data.
- D_OE  out  1  data bus drive enable.
- D_IN  in  16  read data.
- AS_IN  in  1  observed bus AS.
- DTACK  in  1  active-low.
- BERR  in  1  active-low.
- VPA  in  1  active-low.
- E  in  1  6800 E clock.
- VMA  out  1  valid memory address, active-low.

Behaviour:
- Reset (RST=0 at a posedge): state IDLE, and all of the following hold from that edge.
  - BR=BGACK=AS=UDS=LDS=VMA=1, RW=1.
  - BUS_OE=D_OE=0, ACK=0, BUSY=0.
  - RSP_D=0, RSP_ERR=00, timeout counter=0.
  - Reset mid-cycle releases strobes and the bus on the same edge; no ACK is issued.
- States: IDLE, ARB, ADDR, STROBE, WSTROBE, WAIT, ESYNC, TERM, RELEASE.
- IDLE:
  - REQ=1 with REQ_UDS=REQ_LDS=1 → ACK pulse with RSP_ERR=11 on the next cycle; bus untouched.
  - Otherwise latch the request, set BUSY=1, BR=0, go to ARB.
- ARB: wait for BG=0, AS_IN=1 and DTACK=1 in the same sample. Then BGACK=0, BR=1, BUS_OE=1, go to ADDR.
- ADDR (1 cycle): A and RW driven, AS=1. Writes also set D_OE=1 and D_OUT=REQ_D.
- STROBE: AS=0.
  - Read: UDS/LDS asserted this cycle, then WAIT.
  - Write: go to WSTROBE (1 cycle), which asserts UDS/LDS, then WAIT.
- WAIT, priority order per cycle:
  - BERR=0 → TERM with err 01.
  - DTACK=0 → TERM with err 00; reads capture D_IN into RSP_D on this edge.
  - VPA=0 and E_SYNC=1 → ESYNC. VPA=0 and E_SYNC=0 → TERM with err 01.
  - Counter reaches TIMEOUT_CYCLES-1 → TERM with err 10.
  - Counter clears on entry to WAIT. BERR and DTACK together → BERR wins.
- ESYNC:
  - Wait for E low, then assert VMA=0.
  - Wait for E high, then for the next E falling edge (registered previous E=1, current E=0).
  - Reads capture D_IN on that edge, then go to TERM with err 00.
  - BERR during ESYNC → TERM with err 01.
- TERM (1 cycle): AS=UDS=LDS=VMA=1, D_OE=0, ACK=1, RSP_ERR updated, BUSY cleared.
- RELEASE (1 cycle): BUS_OE=0, BGACK=1, RW=1, then IDLE.
  - A REQ seen in RELEASE is not accepted until IDLE, so there is a minimum 1-cycle gap between bus tenures.
- REQ while BUSY is ignored. REQ_* inputs are don't-care after acceptance.
- BUS_OE is 0 whenever BGACK=1; the outputs never drive the bus without a grant.
- Read latency with immediate DTACK: accept→ACK = ARB(≥1)+ADDR+STROBE+WAIT+TERM, which is 5 cycles minimum.

Test Plan:
- Read 0x00FA0000 (UDS=LDS=0), BG granted next cycle, DTACK low on the first WAIT cycle, D_IN=0xBEEF → ACK 5 cycles after REQ; RSP_D=0xBEEF, RSP_ERR=00; BGACK high one cycle after ACK.
- Byte write REQ_D=0x00A5, UDS=1, LDS=0, DTACK after 3 WAIT cycles → D_OE high from ADDR to TERM; LDS low only from WSTROBE; UDS stays 1; RSP_ERR=00.
- No DTACK, TIMEOUT_CYCLES=64 → exactly 64 WAIT cycles, then ACK with RSP_ERR=10; strobes high at the ACK cycle.
- DTACK and BERR asserted in the same WAIT cycle → RSP_ERR=01; RSP_D unchanged.
- VPA=0 in WAIT with E running 6 low/4 high → VMA low until the E falling edge; ACK follows that edge; read data captured at it.
- RST low while in WAIT → next edge AS/UDS/LDS=1, BUS_OE=0, BGACK=1, BR=1, no ACK; a new REQ after RST high completes normally.

Source files
------------

// File: rtl/m68k_bus_master.sv
// 68000-style bus initiator: arbitrates with BR/BG/BGACK, runs one word or byte
// cycle terminated by DTACK, BERR, VPA/E or timeout, then hands the bus back.
module m68k_bus_master #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter bit E_SYNC         = 1'b1
) (
  input  logic        CLK8,
  input  logic        RST,
  input  logic        REQ,
  input  logic        REQ_RW,
  input  logic [22:0] REQ_A,
  input  logic        REQ_UDS,
  input  logic        REQ_LDS,
  input  logic [15:0] REQ_D,
  output logic        ACK,
  output logic [15:0] RSP_D,
  output logic [1:0]  RSP_ERR,
  output logic        BUSY,
  output logic        BR,
  input  logic        BG,
  output logic        BGACK,
  output logic        BUS_OE,
  output logic [22:0] A,
  output logic        AS,
  output logic        UDS,
  output logic        LDS,
  output logic        RW,
  output logic [15:0] D_OUT,
  output logic        D_OE,
  input  logic [15:0] D_IN,
  input  logic        AS_IN,
  input  logic        DTACK,
  input  logic        BERR,
  input  logic        VPA,
  input  logic        E,
  output logic        VMA
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_ARB, S_ADDR, S_STROBE, S_WSTROBE, S_WAIT, S_ESYNC, S_TERM, S_RELEASE
  } state_t;

  // Sub-phases of a 6800 cycle: wait E low, wait E high, wait E falling edge.
  typedef enum logic [1:0] {EPH_LOW, EPH_HIGH, EPH_FALL} eph_t;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_BERR    = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;
  localparam logic [1:0] ERR_REJECT  = 2'b11;

  state_t        state_q, state_d;
  eph_t          eph_q, eph_d;
  logic          rw_q, rw_d;
  logic [22:0]   a_q, a_d;
  logic          uds_q, uds_d;
  logic          lds_q, lds_d;
  logic [15:0]   d_q, d_d;
  logic [15:0]   rsp_d_q, rsp_d_d;
  logic [1:0]    rsp_err_q, rsp_err_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rej_q, rej_d;
  logic          e_q;

  // NOTE: every register, including the latched request, is cleared so the
  // bus-facing outputs are fully defined from the first reset edge.
  always_ff @(posedge CLK8) begin
    if (!RST) begin
      state_q   <= S_IDLE;
      eph_q     <= EPH_LOW;
      rw_q      <= 1'b1;
      a_q       <= '0;
      uds_q     <= 1'b1;
      lds_q     <= 1'b1;
      d_q       <= '0;
      rsp_d_q   <= '0;
      rsp_err_q <= ERR_OK;
      cnt_q     <= '0;
      rej_q     <= 1'b0;
      e_q       <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge value of every other register.
      state_q   <= state_d;
      eph_q     <= eph_d;
      rw_q      <= rw_d;
      a_q       <= a_d;
      uds_q     <= uds_d;
      lds_q     <= lds_d;
      d_q       <= d_d;
      rsp_d_q   <= rsp_d_d;
      rsp_err_q <= rsp_err_d;
      cnt_q     <= cnt_d;
      rej_q     <= rej_d;
      e_q       <= E;
    end
  end

  always_comb begin
    // NOTE: defaults first, so no path through the case leaves a latch behind.
    state_d   = state_q;
    eph_d     = eph_q;
    rw_d      = rw_q;
    a_d       = a_q;
    uds_d     = uds_q;
    lds_d     = lds_q;
    d_d       = d_q;
    rsp_d_d   = rsp_d_q;
    rsp_err_d = rsp_err_q;
    cnt_d     = cnt_q;
    rej_d     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // A reject pulse is in flight during rej_q, so REQ is not sampled then.
        if (REQ && !rej_q) begin
          if (REQ_UDS && REQ_LDS) begin
            rej_d     = 1'b1;
            rsp_err_d = ERR_REJECT;
          end else begin
            rw_d    = REQ_RW;
            a_d     = REQ_A;
            uds_d   = REQ_UDS;
            lds_d   = REQ_LDS;
            d_d     = REQ_D;
            state_d = S_ARB;
          end
        end
      end
      S_ARB: begin
        if (!BG && AS_IN && DTACK) state_d = S_ADDR;
      end
      S_ADDR: state_d = S_STROBE;
      S_STROBE: begin
        state_d = rw_q ? S_WAIT : S_WSTROBE;
        cnt_d   = '0;
      end
      S_WSTROBE: begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end
      S_WAIT: begin
        cnt_d = cnt_q + CW'(1);
        if (!BERR) begin
          state_d   = S_TERM;
          rsp_err_d = ERR_BERR;
        end else if (!DTACK) begin
          state_d   = S_TERM;
          rsp_err_d = ERR_OK;
          if (rw_q) rsp_d_d = D_IN;
        end else if (!VPA) begin
          if (E_SYNC) begin
            state_d = S_ESYNC;
            eph_d   = EPH_LOW;
          end else begin
            state_d   = S_TERM;
            rsp_err_d = ERR_BERR;
          end
        end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          state_d   = S_TERM;
          rsp_err_d = ERR_TIMEOUT;
        end
      end
      S_ESYNC: begin
        if (!BERR) begin
          state_d   = S_TERM;
          rsp_err_d = ERR_BERR;
        end else begin
          unique case (eph_q)
            EPH_LOW:  if (!E) eph_d = EPH_HIGH;
            EPH_HIGH: if (E) eph_d = EPH_FALL;
            EPH_FALL: begin
              if (e_q && !E) begin
                state_d   = S_TERM;
                rsp_err_d = ERR_OK;
                if (rw_q) rsp_d_d = D_IN;
              end
            end
            default:  eph_d = EPH_LOW;
          endcase
        end
      end
      S_TERM:    state_d = S_RELEASE;
      S_RELEASE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  logic tenure, strobing, ds_on;

  // Tenure spans ADDR..TERM; data strobes start one cycle later on writes.
  assign tenure   = state_q inside {S_ADDR, S_STROBE, S_WSTROBE, S_WAIT, S_ESYNC, S_TERM};
  assign strobing = state_q inside {S_STROBE, S_WSTROBE, S_WAIT, S_ESYNC};
  assign ds_on    = strobing && !(state_q == S_STROBE && !rw_q);

  assign BR      = (state_q != S_ARB);
  assign BGACK   = !tenure;
  assign BUS_OE  = tenure;
  assign A       = a_q;
  assign AS      = !strobing;
  assign UDS     = ds_on ? uds_q : 1'b1;
  assign LDS     = ds_on ? lds_q : 1'b1;
  assign RW      = tenure ? rw_q : 1'b1;
  assign D_OUT   = d_q;
  assign D_OE    = !rw_q && tenure && (state_q != S_TERM);
  assign VMA     = !(state_q == S_ESYNC && eph_q != EPH_LOW);
  assign ACK     = (state_q == S_TERM) || rej_q;
  assign BUSY    = state_q inside {S_ARB, S_ADDR, S_STROBE, S_WSTROBE, S_WAIT, S_ESYNC};
  assign RSP_D   = rsp_d_q;
  assign RSP_ERR = rsp_err_q;

endmodule

// File: tb/tb_m68k_bus_master.sv
// Directed bench for m68k_bus_master: a bus responder model, a stimulus thread
// that queues expected completions, and an ACK monitor that scores them.
module tb_m68k_bus_master;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req = 1'b0;
  logic        req_rw = 1'b1;
  logic [22:0] req_a = '0;
  logic        req_uds = 1'b1;
  logic        req_lds = 1'b1;
  logic [15:0] req_d = '0;
  logic        ack;
  logic [15:0] rsp_d;
  logic [1:0]  rsp_err;
  logic        busy, br, bgack, bus_oe, as_o, uds_o, lds_o, rw_o, d_oe, vma;
  logic [22:0] a_o;
  logic [15:0] d_out;
  logic        bg = 1'b1;
  logic [15:0] d_in = '0;
  logic        as_in = 1'b1;
  logic        dtack = 1'b1;
  logic        berr = 1'b1;
  logic        vpa = 1'b1;
  logic        e_clk = 1'b0;

  m68k_bus_master #(.TIMEOUT_CYCLES(64), .E_SYNC(1'b1)) dut (
    .CLK8(clk), .RST(rst), .REQ(req), .REQ_RW(req_rw), .REQ_A(req_a),
    .REQ_UDS(req_uds), .REQ_LDS(req_lds), .REQ_D(req_d),
    .ACK(ack), .RSP_D(rsp_d), .RSP_ERR(rsp_err), .BUSY(busy),
    .BR(br), .BG(bg), .BGACK(bgack), .BUS_OE(bus_oe), .A(a_o),
    .AS(as_o), .UDS(uds_o), .LDS(lds_o), .RW(rw_o), .D_OUT(d_out), .D_OE(d_oe),
    .D_IN(d_in), .AS_IN(as_in), .DTACK(dtack), .BERR(berr), .VPA(vpa),
    .E(e_clk), .VMA(vma)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Responder: terminates resp_after cycles into the data-strobe window.
  typedef enum int {R_NONE, R_DTACK, R_BOTH, R_VPA} resp_t;
  resp_t resp_mode  = R_NONE;
  int    resp_after = 1;
  int    e_base     = 0;
  int    ds_cnt     = 0;

  always @(posedge clk) ds_cnt <= (!uds_o || !lds_o) ? ds_cnt + 1 : 0;

  always @(negedge clk) begin
    logic hit;
    hit   = (!uds_o || !lds_o) && (ds_cnt >= resp_after);
    dtack = !(hit && (resp_mode == R_DTACK || resp_mode == R_BOTH));
    berr  = !(hit && resp_mode == R_BOTH);
    vpa   = !(hit && resp_mode == R_VPA);
    bg    = br;
    as_in = bus_oe ? as_o : 1'b1;
    e_clk = (((cyc - e_base) % 10) >= 6);
  end

  typedef struct {
    int          ack_cyc;
    logic [1:0]  err;
    logic [15:0] rd;
  } exp_t;
  exp_t sb[$];

  always @(negedge clk) begin
    if (ack === 1'b1) begin
      if (sb.size() == 0) begin
        check("ack_unexpected", ack, 1'b0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("ack_cycle", cyc, e.ack_cyc);
        check("rsp_err", rsp_err, e.err);
        check("rsp_d", rsp_d, e.rd);
        check("lines_at_ack", {as_o, uds_o, lds_o, vma, d_oe}, 5'b11110);
      end
    end
  end

  // Called at a negedge; REQ is held for exactly one sampling edge.
  task automatic issue(input logic rw, input logic [22:0] a, input logic uds,
                       input logic lds, input logic [15:0] d, input logic push,
                       input logic [1:0] err, input logic [15:0] rd, input int lat);
    exp_t e;
    req = 1'b1; req_rw = rw; req_a = a; req_uds = uds; req_lds = lds; req_d = d;
    if (push) begin
      e.ack_cyc = cyc + lat; e.err = err; e.rd = rd;
      sb.push_back(e);
    end
    @(negedge clk);
    req = 1'b0; req_rw = ~rw; req_a = ~a; req_uds = 1'b0; req_lds = 1'b0; req_d = ~d;
  endtask

  task automatic wait_done();
    int n = 0;
    while (ack !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("ack_seen", ack, 1'b1);
    @(negedge clk);
    check("release_bus", {bgack, bus_oe, rw_o, busy, br}, 5'b10101);
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_ctl", {br, bgack, as_o, uds_o, lds_o, vma, rw_o}, 7'h7f);
    check("reset_oe", {bus_oe, d_oe, ack, busy}, 4'h0);
    check("reset_rsp", {rsp_d, rsp_err}, 18'h0);
    rst = 1'b1;
    @(negedge clk);

    // Read 0xFA0000 (word address 0x7D0000), DTACK on the first WAIT cycle.
    resp_mode = R_DTACK; resp_after = 1; d_in = 16'hBEEF;
    issue(1'b1, 23'h7D0000, 1'b0, 1'b0, 16'h0, 1'b1, 2'b00, 16'hBEEF, 5);
    check("arb_busy_br", {busy, br}, 2'b10);
    @(negedge clk);
    check("addr_phase", {bgack, bus_oe, rw_o, as_o, d_oe}, 5'b01110);
    check("addr_value", a_o, 23'h7D0000);
    wait_done();

    // Byte write to the lower lane, DTACK in the fourth WAIT cycle.
    resp_mode = R_DTACK; resp_after = 4; d_in = 16'hDEAD;
    issue(1'b0, 23'h000100, 1'b1, 1'b0, 16'h00A5, 1'b1, 2'b00, 16'hBEEF, 9);
    for (int k = 1; k <= 9; k++) begin
      if (k > 1) @(negedge clk);
      check($sformatf("wr_doe_c%0d", k), d_oe, (k >= 2 && k <= 8));
      check($sformatf("wr_lds_c%0d", k), lds_o, !(k >= 4 && k <= 8));
      check($sformatf("wr_uds_c%0d", k), uds_o, 1'b1);
      if (k == 2) check("wr_data_rw", {d_out, rw_o}, {16'h00A5, 1'b0});
    end
    wait_done();

    // No strobe selected: rejected without touching the bus.
    issue(1'b1, 23'h000200, 1'b1, 1'b1, 16'h0, 1'b1, 2'b11, 16'hBEEF, 1);
    check("reject_bus_idle", {br, bgack, busy}, 3'b110);
    wait_done();

    // No response: timeout after exactly 64 WAIT cycles.
    resp_mode = R_NONE;
    issue(1'b1, 23'h000300, 1'b0, 1'b0, 16'h0, 1'b1, 2'b10, 16'hBEEF, 68);
    wait_done();

    // DTACK and BERR together: bus error wins and read data is not captured.
    resp_mode = R_BOTH; resp_after = 1; d_in = 16'h1234;
    issue(1'b1, 23'h000400, 1'b0, 1'b0, 16'h0, 1'b1, 2'b01, 16'hBEEF, 5);
    wait_done();

    // VPA read with E running 6 low / 4 high, E phase aligned to the request.
    resp_mode = R_VPA; resp_after = 1; d_in = 16'hC0DE; e_base = cyc;
    issue(1'b1, 23'h7FF000, 1'b0, 1'b0, 16'h0, 1'b1, 2'b00, 16'hC0DE, 11);
    for (int k = 1; k <= 11; k++) begin
      if (k > 1) @(negedge clk);
      check($sformatf("vma_c%0d", k), vma, !(k >= 6 && k <= 10));
    end
    wait_done();

    // Reset in the middle of WAIT drops everything with no ACK.
    resp_mode = R_NONE;
    issue(1'b1, 23'h000500, 1'b0, 1'b0, 16'h0, 1'b0, 2'b00, 16'h0, 0);
    repeat (4) @(negedge clk);
    check("pre_reset_in_wait", {as_o, bgack}, 2'b00);
    rst = 1'b0;
    @(negedge clk);
    check("rst_strobes", {as_o, uds_o, lds_o, vma}, 4'hf);
    check("rst_bus", {bus_oe, bgack, br, ack, busy}, 5'b01100);
    check("rst_rsp", {rsp_d, rsp_err}, 18'h0);
    rst = 1'b1;
    @(negedge clk);

    resp_mode = R_DTACK; resp_after = 1; d_in = 16'h7777;
    issue(1'b1, 23'h000600, 1'b0, 1'b0, 16'h0, 1'b1, 2'b00, 16'h7777, 5);
    wait_done();

    repeat (3) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
    $fatal(1);
  end

endmodule
